axis_fp16_addc_pipe: RTL and testbench

- Lane-parallel AXI-Stream FP16 adder: every 16-bit lane of each beat gets a runtime FP16 addend added to it; +1.0 (16'h3C00) is the default use.
- Successor to the pass-through FP16 +1.0 stream stage.
- Real IEEE-754 binary16 addition, parametrised width, 3-stage pipeline with full backpressure.
- Sits between the DMA MM2S and S2MM streams in the test datapath.

---
 rtl/axis_fp16_addc_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_axis_fp16_addc_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fp16_addc_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fp16_addc_pipe
//  Purpose  : Lane-parallel AXI-Stream FP16 adder. Every 16-bit lane of each
//             accepted beat has the runtime addend cfg_addend added to it in
//             IEEE-754 binary16 (round-to-nearest-even, flush-to-zero for
//             subnormal inputs and results). 3-stage pipeline, 1 beat/cycle,
//             full backpressure, no internal FIFO.
//  Ports    : aclk, aresetn (sync, active-low)
//             cfg_addend [15:0]      FP16 addend, captured with each beat
//             s_tdata/s_tvalid/s_tready/s_tlast   slave stream (W bits)
//             m_tdata/m_tvalid/m_tready/m_tlast   master stream (W bits)
//  Revision : 1.0  initial release
// ============================================================================
module axis_fp16_addc_pipe #(
   parameter int W     = 128,
   parameter int LANES = W / 16
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic [15:0]  cfg_addend,
   input  logic [W-1:0] s_tdata,
   input  logic         s_tvalid,
   output logic         s_tready,
   input  logic         s_tlast,
   output logic [W-1:0] m_tdata,
   output logic         m_tvalid,
   input  logic         m_tready,
   output logic         m_tlast
);

   // All stages move together; the output register frees up when it is
   // empty or being consumed this cycle.
   logic         en;
   logic         s1_valid, s2_valid;
   logic         s1_last, s2_last;
   logic [W-1:0] res_data;

   assign en       = !m_tvalid || m_tready;
   assign s_tready = en;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_last  <= 1'b0;
         s2_last  <= 1'b0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tdata  <= '0;
      end else if (en) begin
         s1_valid <= s_tvalid;
         s2_valid <= s1_valid;
         m_tvalid <= s2_valid;
         if (s_tvalid) s1_last <= s_tlast;
         if (s1_valid) s2_last <= s1_last;
         if (s2_valid) begin
            m_tdata <= res_data;
            m_tlast <= s2_last;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         // ---------------- S1: classify, swap, align ----------------
         logic [15:0] a, b;
         logic        a_nan, b_nan, a_inf, b_inf;
         logic [14:0] a_mag, b_mag, big_mag, small_mag;
         logic        swap;
         logic [10:0] big_sig, small_sig;
         logic [4:0]  exp_diff;
         logic [3:0]  shamt;
         logic [27:0] small_wide;
         logic        c1_spec;
         logic [15:0] c1_spec_val;

         logic        s1_spec;
         logic [15:0] s1_spec_val;
         logic        s1_sign, s1_sub, s1_both_neg;
         logic [4:0]  s1_exp;
         logic [13:0] s1_big, s1_small;

         assign a = s_tdata[16*gi +: 16];
         assign b = cfg_addend;

         always_comb begin
            a_nan = (&a[14:10]) && (|a[9:0]);
            b_nan = (&b[14:10]) && (|b[9:0]);
            a_inf = (&a[14:10]) && !(|a[9:0]);
            b_inf = (&b[14:10]) && !(|b[9:0]);
            // Subnormals collapse to a magnitude of zero (flush-to-zero).
            a_mag = (a[14:10] == 5'd0) ? 15'd0 : a[14:0];
            b_mag = (b[14:10] == 5'd0) ? 15'd0 : b[14:0];
            swap      = b_mag > a_mag;
            big_mag   = swap ? b_mag : a_mag;
            small_mag = swap ? a_mag : b_mag;
            big_sig   = (big_mag[14:10]   == 5'd0) ? 11'd0 : {1'b1, big_mag[9:0]};
            small_sig = (small_mag[14:10] == 5'd0) ? 11'd0 : {1'b1, small_mag[9:0]};
            exp_diff  = big_mag[14:10] - small_mag[14:10];
            // Anything beyond 15 has already left the guard/round window, so
            // saturating keeps the shifter small without losing the sticky.
            shamt      = (exp_diff > 5'd15) ? 4'd15 : exp_diff[3:0];
            small_wide = {small_sig, 17'd0} >> shamt;

            c1_spec     = 1'b0;
            c1_spec_val = 16'h0000;
            if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
               c1_spec     = 1'b1;
               c1_spec_val = 16'h7E00;
            end else if (a_inf) begin
               c1_spec     = 1'b1;
               c1_spec_val = a;
            end else if (b_inf) begin
               c1_spec     = 1'b1;
               c1_spec_val = b;
            end
         end

         always_ff @(posedge aclk) begin
            if (en && s_tvalid) begin
               s1_spec     <= c1_spec;
               s1_spec_val <= c1_spec_val;
               s1_sign     <= swap ? b[15] : a[15];
               s1_sub      <= a[15] ^ b[15];
               s1_both_neg <= a[15] & b[15];
               s1_exp      <= big_mag[14:10];
               s1_big      <= {big_sig, 3'b000};
               // Bits shifted past the guard/round positions fold into sticky.
               s1_small    <= {small_wide[27:15], |small_wide[14:0]};
            end
         end

         // ---------------- S2: add/sub, LZC, normalise ----------------
         logic [14:0] sum;
         logic [3:0]  lz;
         logic [13:0] norm;
         logic [6:0]  exp_n;
         logic        underflow;
         logic        c2_spec;
         logic [15:0] c2_spec_val;

         logic        s2_spec;
         logic [15:0] s2_spec_val;
         logic        s2_sign;
         logic [5:0]  s2_exp;
         logic [12:0] s2_mant;

         always_comb begin
            // The larger magnitude sits in s1_big, so subtraction never goes negative.
            sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                         : ({1'b0, s1_big} + {1'b0, s1_small});
            lz = 4'd14;
            for (int k = 0; k < 14; k++) begin
               if (sum[k]) lz = 4'(13 - k);
            end
            if (sum[14]) begin
               norm  = {sum[14:2], sum[1] | sum[0]};
               exp_n = {2'b00, s1_exp} + 7'd1;
            end else begin
               norm  = sum[13:0] << lz;
               exp_n = {2'b00, s1_exp} - {3'b000, lz};
            end
            // exp_n is two's complement; zero or negative means the result
            // would be subnormal.
            underflow = exp_n[6] || (exp_n == 7'd0);

            c2_spec     = s1_spec;
            c2_spec_val = s1_spec_val;
            if (!s1_spec) begin
               if (!norm[13]) begin
                  // Exact zero: only (-0)+(-0) keeps the negative sign.
                  c2_spec     = 1'b1;
                  c2_spec_val = {s1_both_neg, 15'd0};
               end else if (underflow) begin
                  c2_spec     = 1'b1;
                  c2_spec_val = {s1_sign, 15'd0};
               end
            end
         end

         always_ff @(posedge aclk) begin
            if (en && s1_valid) begin
               s2_spec     <= c2_spec;
               s2_spec_val <= c2_spec_val;
               s2_sign     <= s1_sign;
               s2_exp      <= exp_n[5:0];
               // Leading one is implicit from here on.
               s2_mant     <= norm[12:0];
            end
         end

         // ---------------- S3: round, overflow, pack ----------------
         logic        round_up;
         logic [10:0] frac_r;
         logic [5:0]  exp_r;
         logic [15:0] lane_res;

         always_comb begin
            round_up = s2_mant[2] && (s2_mant[1] || s2_mant[0] || s2_mant[3]);
            // A carry out of the fraction means 1.111..1 rounded to 10.0:
            // bump the exponent and the fraction wraps to zero.
            frac_r = {1'b0, s2_mant[12:3]} + {10'd0, round_up};
            exp_r  = s2_exp + {5'd0, frac_r[10]};
            if (s2_spec) begin
               lane_res = s2_spec_val;
            end else if (exp_r >= 6'd31) begin
               lane_res = {s2_sign, 5'h1F, 10'd0};
            end else begin
               lane_res = {s2_sign, exp_r[4:0], frac_r[9:0]};
            end
         end

         assign res_data[16*gi +: 16] = lane_res;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_fp16_addc_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_fp16_addc_pipe
//  Purpose  : Self-checking bench for axis_fp16_addc_pipe (W=128, 8 lanes).
//             Directed FP16 corner beats plus randomized packets with a
//             toggling m_tready, checked against an exact-arithmetic
//             binary16 reference model and a beat scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_fp16_addc_pipe;
   localparam int W     = 128;
   localparam int LANES = W / 16;

   logic         aclk = 1'b0;
   logic         aresetn;
   logic [15:0]  cfg_addend;
   logic [W-1:0] s_tdata;
   logic         s_tvalid;
   logic         s_tready;
   logic         s_tlast;
   logic [W-1:0] m_tdata;
   logic         m_tvalid;
   logic         m_tready;
   logic         m_tlast;

   always #5 aclk = ~aclk;

   axis_fp16_addc_pipe #(.W(W)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .cfg_addend (cfg_addend),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .s_tlast    (s_tlast),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast)
   );

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      int           tag;
   } beat_t;

   beat_t        sb[$];
   int           compared   = 0;
   int           mismatched = 0;
   int           en_cnt     = 0;
   logic [W-1:0] cur_exp;
   logic         hold_pending = 1'b0;
   logic [W-1:0] hold_data;
   logic         hold_last;
   logic         rand_ready = 1'b0;
   int           low_run    = 0;
   logic         accepted;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: exact sum as a scaled integer, then RNE to binary16.
   function automatic logic [15:0] fp16_ref(input logic [15:0] a, input logic [15:0] b);
      bit     a_nan, b_nan, a_inf, b_inf, neg;
      longint va, vb, s, m, q, rem, half;
      int     p, e, sh;
      a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
      b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
      a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
      b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
      if (a_nan || b_nan) return 16'h7E00;
      if (a_inf && b_inf) return (a[15] == b[15]) ? a : 16'h7E00;
      if (a_inf) return a;
      if (b_inf) return b;
      va = (a[14:10] == 5'd0) ? 64'sd0 : (longint'(1024 + int'(a[9:0])) << (int'(a[14:10]) - 1));
      vb = (b[14:10] == 5'd0) ? 64'sd0 : (longint'(1024 + int'(b[9:0])) << (int'(b[14:10]) - 1));
      if (a[15]) va = -va;
      if (b[15]) vb = -vb;
      s = va + vb;
      if (s == 0) return {a[15] & b[15], 15'd0};
      neg = (s < 0);
      m   = neg ? -s : s;
      p   = 0;
      for (int k = 0; k < 63; k++) if (m[k]) p = k;
      e = p - 9;
      if (e <= 0) return {neg, 15'd0};
      sh   = p - 10;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = (sh == 0) ? 64'sd0 : (64'sd1 << (sh - 1));
      if (sh > 0 && (rem > half || (rem == half && q[0]))) q++;
      if (q == 2048) begin
         q = 1024;
         e++;
      end
      if (e >= 31) return {neg, 5'h1F, 10'd0};
      return {neg, 5'(e), q[9:0]};
   endfunction

   function automatic logic [W-1:0] model_vec(input logic [W-1:0] d, input logic [15:0] add);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) r[16*i +: 16] = fp16_ref(d[16*i +: 16], add);
      return r;
   endfunction

   function automatic logic [W-1:0] mk8(input logic [15:0] l0, l1, l2, l3, l4, l5, l6, l7);
      return {l7, l6, l5, l4, l3, l2, l1, l0};
   endfunction

   function automatic logic [15:0] rand_lane(input logic [15:0] add);
      logic [15:0] r;
      int          e;
      r = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
         e = int'(add[14:10]) + int'($urandom_range(0, 6)) - 3;
         if (e < 1)  e = 1;
         if (e > 30) e = 30;
         r[14:10] = 5'(e);
      end
      return r;
   endfunction

   // One clock cycle: entered and left at a falling edge with inputs set.
   task automatic tick();
      beat_t it;
      logic  en_now;
      int    r;
      if (rand_ready) begin
         if (low_run > 0) begin
            m_tready = 1'b0;
            low_run--;
         end else begin
            r = int'($urandom_range(0, 7));
            if (r == 0) begin
               m_tready = 1'b0;
               low_run  = 4;
            end else begin
               m_tready = (r > 2);
            end
         end
      end
      #1;
      en_now = !m_tvalid || m_tready;
      chk("s_tready", W'(s_tready), W'(en_now));
      if (hold_pending) begin
         chk("stall_valid", W'(m_tvalid), W'(1));
         chk("stall_data", m_tdata, hold_data);
         chk("stall_last", W'(m_tlast), W'(hold_last));
      end
      hold_pending = m_tvalid && !m_tready;
      hold_data    = m_tdata;
      hold_last    = m_tlast;
      if (m_tvalid && m_tready) begin
         if (sb.size() == 0) begin
            chk("extra_beat", W'(m_tvalid), W'(0));
         end else begin
            it = sb.pop_front();
            chk("data", m_tdata, it.data);
            chk("last", W'(m_tlast), W'(it.last));
            chk("latency", W'(en_cnt - it.tag), W'(3));
         end
      end
      accepted = s_tvalid && s_tready;
      if (accepted) sb.push_back('{cur_exp, s_tlast, en_cnt});
      if (en_now) en_cnt++;
      @(posedge aclk);
      @(negedge aclk);
   endtask

   task automatic send(input logic [W-1:0] d, input logic [15:0] add, input logic last,
                       input logic [W-1:0] expv);
      s_tdata    = d;
      cfg_addend = add;
      s_tlast    = last;
      s_tvalid   = 1'b1;
      cur_exp    = expv;
      accepted   = 1'b0;
      for (int n = 0; n < 200 && !accepted; n++) tick();
      if (!accepted) chk("send_timeout", W'(accepted), W'(1));
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic idle(input int n);
      s_tvalid = 1'b0;
      for (int i = 0; i < n; i++) begin
         s_tdata    = {4{32'($urandom)}};
         cfg_addend = 16'($urandom);
         s_tlast    = 1'($urandom);
         tick();
      end
      s_tlast = 1'b0;
   endtask

   task automatic drain();
      s_tvalid = 1'b0;
      for (int n = 0; n < 300 && sb.size() > 0; n++) tick();
      if (sb.size() != 0) chk("drain_timeout", W'(sb.size()), W'(0));
   endtask

   task automatic do_reset(input int cycles);
      aresetn  = 1'b0;
      s_tvalid = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge aclk);
         @(negedge aclk);
      end
      aresetn      = 1'b1;
      hold_pending = 1'b0;
      sb.delete();
      chk("rst_m_tvalid", W'(m_tvalid), W'(0));
      chk("rst_m_tlast", W'(m_tlast), W'(0));
      chk("rst_m_tdata", m_tdata, '0);
   endtask

   logic [W-1:0] v_in, v_exp;
   logic [15:0]  add;

   initial begin
      aresetn    = 1'b0;
      s_tdata    = '0;
      s_tvalid   = 1'b0;
      s_tlast    = 1'b0;
      cfg_addend = 16'h3C00;
      m_tready   = 1'b1;
      @(negedge aclk);
      do_reset(2);

      // Basic +1.0, back-to-back, last on second beat.
      v_in  = mk8(16'h0000, 16'h3C00, 16'h3800, 16'hBC00, 16'h0000, 16'h3C00, 16'h3800, 16'hBC00);
      v_exp = mk8(16'h3C00, 16'h4000, 16'h3E00, 16'h0000, 16'h3C00, 16'h4000, 16'h3E00, 16'h0000);
      send(v_in, 16'h3C00, 1'b0, v_exp);
      send(v_in, 16'h3C00, 1'b1, v_exp);
      drain();
      idle(3);

      // Rounding, overflow and special-value beats.
      send(mk8(16'h6800, 16'h6801, 16'h7BFF, 16'h7E01, 16'h7C00, 16'hFC00, 16'h0000, 16'h8000), 16'h3C00, 1'b0,
           mk8(16'h6800, 16'h6802, 16'h7BFF, 16'h7E00, 16'h7C00, 16'hFC00, 16'h3C00, 16'h3C00));
      send(mk8(16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, 16'hFBFF, 16'hFBFF, 16'hFBFF, 16'hFBFF), 16'h7BFF, 1'b0,
           mk8(16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
      send(mk8(16'h7C00, 16'h7E01, 16'h3C00, 16'hFC00, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'hFC00, 1'b0,
           mk8(16'h7E00, 16'h7E00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00));
      send(mk8(16'h0001, 16'h8001, 16'h3C00, 16'h0000, 16'h8000, 16'h03FF, 16'h0400, 16'hBC00), 16'h0000, 1'b0,
           mk8(16'h0000, 16'h0000, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'hBC00));
      send(mk8(16'h8000, 16'h0000, 16'h8001, 16'hBC00, 16'h3C00, 16'h8000, 16'h8000, 16'h8000), 16'h8000, 1'b0,
           mk8(16'h8000, 16'h0000, 16'h8000, 16'hBC00, 16'h3C00, 16'h8000, 16'h8000, 16'h8000));
      send(mk8(16'h0401, 16'h0800, 16'h0400, 16'h8400, 16'h3C00, 16'h0000, 16'h7C00, 16'h7E00), 16'h8400, 1'b1,
           mk8(16'h0000, 16'h0400, 16'h0000, 16'h8800, 16'h3C00, 16'h8400, 16'h7C00, 16'h7E00));
      drain();
      idle(2);

      // Addend switched between beats 3 and 4 while earlier beats are in flight.
      for (int bt = 1; bt <= 6; bt++) begin
         send({LANES{16'h3C00}}, (bt <= 3) ? 16'h3C00 : 16'h4000, (bt == 6),
              (bt <= 3) ? {LANES{16'h4000}} : {LANES{16'h4200}});
      end
      drain();
      idle(2);

      // Random 16-beat packets, random bubbles, pseudo-random m_tready.
      rand_ready = 1'b1;
      for (int pk = 0; pk < 3; pk++) begin
         for (int bt = 0; bt < 16; bt++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            add = ($urandom_range(0, 1) == 1) ? 16'h3C00 : rand_lane(16'h3C00);
            for (int ln = 0; ln < LANES; ln++) v_in[16*ln +: 16] = rand_lane(add);
            send(v_in, add, (bt == 15), model_vec(v_in, add));
         end
      end
      drain();
      rand_ready = 1'b0;
      m_tready   = 1'b1;
      idle(4);

      // Reset with three beats in flight: nothing may come out afterwards.
      v_in  = mk8(16'h0000, 16'h3C00, 16'h3800, 16'hBC00, 16'h0000, 16'h3C00, 16'h3800, 16'hBC00);
      v_exp = mk8(16'h3C00, 16'h4000, 16'h3E00, 16'h0000, 16'h3C00, 16'h4000, 16'h3E00, 16'h0000);
      send(v_in, 16'h3C00, 1'b0, v_exp);
      send(v_in, 16'h3C00, 1'b0, v_exp);
      send(v_in, 16'h3C00, 1'b1, v_exp);
      do_reset(1);
      idle(8);

      // Normal operation resumes after reset.
      send(v_in, 16'h3C00, 1'b1, v_exp);
      drain();
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
